// File: rtl/sdhci_busy_timeout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdhci_busy_timeout_ctrl
// Purpose  : Sequences the DAT0 busy phase that follows an R1b response and
//            enforces the data timeout on it. Busy detection runs on SD-clock
//            strobes; the timeout runs on clk_i through a TMCLK prescaler.
// Ports    : clk_i         - system clock
//            rst_i         - synchronous active-high reset
//            start_i       - pulse, R1b end bit received: begin busy phase
//            abort_i       - pulse, DAT-line reset: cancel silently
//            timeout_exp_i - timeout = TimeoutDivider * 2^(13+exp) clk_i cycles
//            sd_clk_en_i   - one-cycle strobe per SD clock rising edge
//            dat0_i        - synchronised DAT0 level (0 = busy)
//            busy_o        - high while WAIT_START or BUSY
//            done_o        - one-cycle pulse: busy released / never asserted
//            timeout_o     - one-cycle pulse: data timeout error
// Revision : 1.0 - initial release
// ============================================================================
module sdhci_busy_timeout_ctrl #(
  parameter int TimeoutDivider  = 13,
  parameter int BusyStartCycles = 2,
  parameter int MaxExponent     = 14
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [3:0] timeout_exp_i,
  input  logic       sd_clk_en_i,
  input  logic       dat0_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o
);

  localparam int PRESC_W = (TimeoutDivider > 1) ? $clog2(TimeoutDivider) : 1;
  localparam int START_W = (BusyStartCycles > 1) ? $clog2(BusyStartCycles) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TimeoutDivider - 1);
  // The start cycle itself is the first counted clk_i cycle, so the counters
  // are preloaded with the state they would hold one cycle after start. This
  // places timeout_o exactly TimeoutDivider*2^(13+exp) cycles after start.
  localparam logic [PRESC_W-1:0] PRESC_INIT = (TimeoutDivider > 1) ? PRESC_W'(1) : '0;
  localparam logic [27:0]        TICKS_INIT = (TimeoutDivider > 1) ? 28'd0 : 28'd1;
  localparam logic [START_W-1:0] START_LAST = START_W'(BusyStartCycles - 1);
  localparam logic [3:0]         EXP_MAX    = 4'(MaxExponent);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    BUSY       = 2'd2
  } state_t;

  state_t               state;
  logic [PRESC_W-1:0]   presc;
  logic [27:0]          ticks;
  logic [START_W-1:0]   start_cnt;
  logic [3:0]           exp_q;

  logic [3:0]  exp_clamped;
  logic [27:0] tick_limit;
  logic        presc_wrap;
  logic        timeout_hit;
  logic        release_hit;

  assign exp_clamped = (timeout_exp_i > EXP_MAX) ? EXP_MAX : timeout_exp_i;
  assign tick_limit  = 28'd1 << (5'd13 + {1'b0, exp_q});
  assign presc_wrap  = (presc == PRESC_LAST);

  // Timeout is decided one cycle early so the registered pulse lands on the
  // cycle in which the tick counter reaches the limit.
  assign timeout_hit = presc_wrap && ((ticks + 28'd1) == tick_limit);

  // Release: DAT0 high on a strobe while busy, or the last allowed strobe of
  // the start window passing with DAT0 still high (card never went busy).
  assign release_hit = sd_clk_en_i && dat0_i &&
                       ((state == BUSY) ||
                        ((state == WAIT_START) && (start_cnt == START_LAST)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      presc     <= '0;
      ticks     <= '0;
      start_cnt <= '0;
      exp_q     <= '0;
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      if (abort_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state     <= WAIT_START;
              busy_o    <= 1'b1;
              exp_q     <= exp_clamped;
              presc     <= PRESC_INIT;
              ticks     <= TICKS_INIT;
              start_cnt <= '0;
            end
          end
          WAIT_START, BUSY: begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap && (ticks != '1)) begin
              ticks <= ticks + 28'd1;
            end
            // Release is checked first: done beats a coincident timeout.
            if (release_hit) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else if (timeout_hit) begin
              state     <= IDLE;
              busy_o    <= 1'b0;
              timeout_o <= 1'b1;
            end else if (sd_clk_en_i && (state == WAIT_START)) begin
              if (!dat0_i) begin
                state <= BUSY;
              end else begin
                start_cnt <= start_cnt + 1'b1;
              end
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdhci_busy_timeout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdhci_busy_timeout_ctrl
// Purpose  : Directed self-checking bench for sdhci_busy_timeout_ctrl.
//            The DUT runs with TimeoutDivider=2 and MaxExponent=1 so full
//            timeouts stay short: exp=0 -> 16384 cycles, exp>=1 -> 32768.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdhci_busy_timeout_ctrl;

  localparam int TO_EXP0 = 2 * 8192;
  localparam int TO_EXP1 = 2 * 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] timeout_exp = 4'd0;
  logic       sd_clk_en = 1'b0;
  logic       dat0 = 1'b1;
  logic       busy;
  logic       done;
  logic       tout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdhci_busy_timeout_ctrl #(
    .TimeoutDivider (2),
    .BusyStartCycles(2),
    .MaxExponent    (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .timeout_exp_i(timeout_exp),
    .sd_clk_en_i  (sd_clk_en),
    .dat0_i       (dat0),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (tout)
  );

  // Advance to just after the next rising edge; outputs read here belong to
  // the new cycle and inputs written here are sampled at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start in the current cycle (cycle 0); returns in cycle 1.
  task automatic do_start(input logic [3:0] e);
    start       = 1'b1;
    timeout_exp = e;
    step();
    start       = 1'b0;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    abort     = 1'b0;
    sd_clk_en = 1'b0;
    dat0      = 1'b1;
  endtask

  task automatic test_reset();
    logic eb;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy/done/timeout=%b%b%b expected 000", busy, done, tout);
    end
    step();
    // Reset in the middle of a busy phase: outputs drop, no pulses.
    do_start(4'd0);
    for (int k = 1; k <= 30; k++) begin
      eb = (k <= 20);
      checks++;
      if (busy !== eb || done !== 1'b0 || tout !== 1'b0) begin
        errors++;
        $display("FAIL reset_midop cyc=%0d busy/done/timeout=%b%b%b expected %b00", k, busy, done, tout, eb);
        break;
      end
      sd_clk_en = (k % 4 == 0);
      dat0      = 1'b0;
      rst       = (k >= 20 && k < 22);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  // DAT0 low at strobe 1, released on strobe 301 (cycle 1204).
  task automatic test_release();
    logic eb, ed;
    do_start(4'd0);
    for (int k = 1; k <= 1210; k++) begin
      eb = (k <= 1204);
      ed = (k == 1205);
      checks++;
      if (busy !== eb || done !== ed || tout !== 1'b0) begin
        errors++;
        $display("FAIL release cyc=%0d busy/done/timeout=%b%b%b expected %b%b0", k, busy, done, tout, eb, ed);
        break;
      end
      sd_clk_en = (k % 4 == 0);
      dat0      = (k >= 4 && k < 1204) ? 1'b0 : 1'b1;
      step();
    end
    idle_inputs();
    step();
  endtask

  // No busy: DAT0 high on strobes 1,2 (low between strobes, which must be
  // ignored). Then start again the cycle after done.
  task automatic test_back_to_back();
    logic eb, ed;
    do_start(4'd0);
    for (int k = 1; k <= 12; k++) begin
      eb = (k <= 8) || (k >= 11);
      ed = (k == 9);
      checks++;
      if (busy !== eb || done !== ed || tout !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d busy/done/timeout=%b%b%b expected %b%b0", k, busy, done, tout, eb, ed);
        break;
      end
      sd_clk_en   = (k % 4 == 0) && (k <= 8);
      dat0        = (k % 4 == 0) ? 1'b1 : 1'b0;
      start       = (k == 10);
      timeout_exp = 4'd0;
      step();
    end
    idle_inputs();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  // DAT0 held low; a second start mid-BUSY and a change of timeout_exp must
  // not disturb the original timeout instant.
  task automatic test_timeout();
    logic eb, et;
    do_start(4'd0);
    for (int k = 1; k <= TO_EXP0 + 2; k++) begin
      eb = (k < TO_EXP0);
      et = (k == TO_EXP0);
      checks++;
      if (busy !== eb || done !== 1'b0 || tout !== et) begin
        errors++;
        $display("FAIL timeout cyc=%0d busy/done/timeout=%b%b%b expected %b0%b", k, busy, done, tout, eb, et);
        break;
      end
      sd_clk_en   = (k % 4 == 0);
      dat0        = 1'b0;
      start       = (k == 100);
      timeout_exp = (k == 100) ? 4'd1 : 4'hF;
      step();
    end
    idle_inputs();
    step();
  endtask

  // Release strobe in the same cycle the timeout is decided: done wins.
  task automatic test_release_vs_timeout();
    logic eb, ed;
    do_start(4'd0);
    for (int k = 1; k <= TO_EXP0 + 2; k++) begin
      eb = (k < TO_EXP0);
      ed = (k == TO_EXP0);
      checks++;
      if (busy !== eb || done !== ed || tout !== 1'b0) begin
        errors++;
        $display("FAIL release_vs_timeout cyc=%0d busy/done/timeout=%b%b%b expected %b%b0", k, busy, done, tout, eb, ed);
        break;
      end
      sd_clk_en = (k % 4 == 0) || (k == TO_EXP0 - 1);
      dat0      = (k == TO_EXP0 - 1) ? 1'b1 : 1'b0;
      step();
    end
    idle_inputs();
    step();
  endtask

  // Abort in BUSY, abort beating a same-cycle start, then a fresh start with
  // exp=4'hF clamped to 1 running a full-length timeout.
  task automatic test_abort_clamp();
    logic eb, et;
    do_start(4'd0);
    for (int k = 1; k <= 62; k++) begin
      eb = (k <= 50);
      checks++;
      if (busy !== eb || done !== 1'b0 || tout !== 1'b0) begin
        errors++;
        $display("FAIL abort cyc=%0d busy/done/timeout=%b%b%b expected %b00", k, busy, done, tout, eb);
        break;
      end
      sd_clk_en = (k % 4 == 0);
      dat0      = 1'b0;
      abort     = (k == 50) || (k == 60);
      start     = (k == 60);
      step();
    end
    idle_inputs();
    do_start(4'hF);
    for (int k = 1; k <= TO_EXP1 + 2; k++) begin
      eb = (k < TO_EXP1);
      et = (k == TO_EXP1);
      checks++;
      if (busy !== eb || done !== 1'b0 || tout !== et) begin
        errors++;
        $display("FAIL clamp_timeout cyc=%0d busy/done/timeout=%b%b%b expected %b0%b", k, busy, done, tout, eb, et);
        break;
      end
      sd_clk_en = (k % 4 == 0);
      dat0      = 1'b0;
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_release();
    test_back_to_back();
    test_timeout();
    test_release_vs_timeout();
    test_abort_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
